// File: rtl/s2c_pkg.sv
// Shared types and helpers for the multi-channel SV-to-SystemC request path.
// The state enum carries a synthetic-response state used only when S2C_REQ_TIMEOUT_EN is defined.
package s2c_pkg;

  typedef enum logic [2:0] {
    S2C_IDLE,
    S2C_SEND_ID,
    S2C_SEND_BODY,
    S2C_WAIT_RSP,
    S2C_RECV,
    S2C_DONE,
    S2C_SYN_RSP
  } s2c_state_e;

  localparam int          S2C_MAX_CH      = 16;
  localparam logic [63:0] S2C_RET_TIMEOUT = '1;

  // One-hot grant for the first set request at or after ptr, wrapping within n channels.
  function automatic logic [S2C_MAX_CH-1:0] rr_pick(input logic [S2C_MAX_CH-1:0] req,
                                                    input logic [3:0]            ptr,
                                                    input int                    n);
    logic [S2C_MAX_CH-1:0] g;
    logic [3:0]            j;
    logic                  found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < S2C_MAX_CH; i++) begin
      if (i < n && !found) begin
        j = 4'((int'(ptr) + i) % n);
        if (req[j]) begin
          g[j]  = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/s2c_rr_arb.sv
// Round-robin arbiter: combinational pick from rr_ptr, pointer advances past the winner on adv.
// Kept standalone so other bridge muxes can share it.
module s2c_rr_arb
  import s2c_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [PW-1:0]         rr_ptr;
  logic [S2C_MAX_CH-1:0] pick;

  always_comb pick = rr_pick(S2C_MAX_CH'(req), 4'(rr_ptr), N);

  assign gnt = pick[N-1:0];
  assign any = |pick;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++)
      if (pick[i]) gnt_idx = PW'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (adv && any)
      rr_ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
  end

endmodule

// File: rtl/s2c_req_arb.sv
// NCH-channel round-robin request arbiter onto a single word-serial bridge port.
// Optional response watchdog with synthetic timeout response: define S2C_REQ_TIMEOUT_EN.
module s2c_req_arb
  import s2c_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DATA_SIZE   = 16,
  parameter int WIDTH       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_req,
  output logic [NCH-1:0]   ch_gnt,
  output logic [NCH-1:0]   ch_done,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  input  logic             rx_ready,
  output logic             br_valid,
  output logic [WIDTH-1:0] br_data,
  input  logic             br_ready,
  input  logic             br_rsp_valid,
  input  logic [WIDTH-1:0] br_rsp_data,
  output logic             br_rsp_ready,
  output logic             busy
);

  localparam int            IW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int            CW   = $clog2(DATA_SIZE + 2);
  localparam logic [CW-1:0] LAST = CW'(DATA_SIZE);

  if (NCH < 1 || NCH > S2C_MAX_CH || DATA_SIZE < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("s2c_req_arb: parameter out of range");
  end

  s2c_state_e     state, nxt;
  logic [NCH-1:0] gnt_q, pick_gnt;
  logic [IW-1:0]  gnt_idx_q, pick_idx;
  logic           pick_any, gnt_take;
  logic [CW-1:0]  word_cnt;
  logic           id_acc, tx_acc, rsp_acc, syn_acc, to_hit;

  assign gnt_take = (state == S2C_IDLE) && pick_any;
  assign id_acc   = (state == S2C_SEND_ID) && br_ready;
  assign tx_acc   = (state == S2C_SEND_BODY) && tx_valid && br_ready;
  assign rsp_acc  = (state == S2C_WAIT_RSP || state == S2C_RECV) && br_rsp_valid && rx_ready;

  s2c_rr_arb #(.N(NCH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ch_req),
    .adv     (gnt_take),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

`ifdef S2C_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;
  logic [CW-1:0] drain_cnt;
  logic          drain_acc;

  assign syn_acc   = (state == S2C_SYN_RSP) && rx_ready;
  assign to_hit    = (state == S2C_WAIT_RSP) && !rsp_acc && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign drain_acc = (state == S2C_IDLE) && (drain_cnt != '0) && br_rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state == S2C_WAIT_RSP && !rsp_acc)
      to_cnt <= to_cnt + TW'(1);
    else
      to_cnt <= '0;
  end

  // A bridge that answers after the watchdog fired still owes a full packet; swallow it in IDLE.
  // If a new grant leaves IDLE first, the remainder of the drain resumes on the next IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drain_cnt <= '0;
    else if (syn_acc && word_cnt == LAST)
      drain_cnt <= CW'(DATA_SIZE + 1);
    else if (drain_acc)
      drain_cnt <= drain_cnt - CW'(1);
  end
`else
  assign syn_acc = 1'b0;
  assign to_hit  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S2C_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S2C_IDLE:      if (pick_any) nxt = S2C_SEND_ID;
      S2C_SEND_ID:   if (br_ready) nxt = S2C_SEND_BODY;
      S2C_SEND_BODY: if (tx_acc && word_cnt == LAST) nxt = S2C_WAIT_RSP;
      S2C_WAIT_RSP: begin
        if (rsp_acc)     nxt = (word_cnt == LAST) ? S2C_DONE : S2C_RECV;
        else if (to_hit) nxt = S2C_SYN_RSP;
      end
      S2C_RECV:      if (rsp_acc && word_cnt == LAST) nxt = S2C_DONE;
      S2C_SYN_RSP:   if (syn_acc && word_cnt == LAST) nxt = S2C_DONE;
      S2C_DONE:      nxt = S2C_IDLE;
      default:       nxt = S2C_IDLE;
    endcase
  end

  // Grant index/one-hot are held until the next grant so DONE can still address the channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      gnt_idx_q <= '0;
    end else if (gnt_take) begin
      gnt_q     <= pick_gnt;
      gnt_idx_q <= pick_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_cnt <= '0;
    else if (id_acc || state == S2C_DONE)
      word_cnt <= '0;
    else if (tx_acc || rsp_acc || syn_acc)
      word_cnt <= (word_cnt == LAST) ? '0 : word_cnt + CW'(1);
  end

  always_comb begin
    ch_gnt       = '0;
    ch_done      = '0;
    tx_ready     = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = '0;
    br_valid     = 1'b0;
    br_data      = '0;
    br_rsp_ready = 1'b0;
    busy         = (state != S2C_IDLE);
    unique case (state)
      S2C_IDLE: begin
`ifdef S2C_REQ_TIMEOUT_EN
        br_rsp_ready = (drain_cnt != '0);
`endif
      end
      S2C_SEND_ID: begin
        ch_gnt   = gnt_q;
        br_valid = 1'b1;
        br_data  = WIDTH'(gnt_idx_q);
      end
      S2C_SEND_BODY: begin
        ch_gnt   = gnt_q;
        br_valid = tx_valid;
        br_data  = tx_data;
        tx_ready = br_ready;
      end
      S2C_WAIT_RSP, S2C_RECV: begin
        ch_gnt       = gnt_q;
        rx_valid     = br_rsp_valid;
        rx_data      = br_rsp_data;
        br_rsp_ready = rx_ready;
      end
      S2C_SYN_RSP: begin
        ch_gnt   = gnt_q;
        rx_valid = 1'b1;
        rx_data  = (word_cnt == '0) ? S2C_RET_TIMEOUT[WIDTH-1:0] : '0;
      end
      S2C_DONE: ch_done = gnt_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_s2c_req_arb.sv
// Randomized self-checking bench for s2c_req_arb; reference is a packet-level channel/bridge model.
// Build with S2C_REQ_TIMEOUT_EN to exercise the watchdog path instead of the indefinite wait.
module tb_s2c_req_arb;

  localparam int NCH = 4;
  localparam int DS  = 16;
  localparam int W   = 32;
  localparam int TO  = 50;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_req, ch_gnt, ch_done;
  logic           tx_valid, tx_ready, rx_valid, rx_ready;
  logic [W-1:0]   tx_data, rx_data, br_data, br_rsp_data;
  logic           br_valid, br_ready, br_rsp_valid, br_rsp_ready, busy;

  logic [1:0]     s_ch_req, s_ch_gnt, s_ch_done;
  logic           s_tx_valid, s_tx_ready, s_rx_valid, s_rx_ready;
  logic [W-1:0]   s_tx_data, s_rx_data, s_br_data, s_br_rsp_data;
  logic           s_br_valid, s_br_ready, s_br_rsp_valid, s_br_rsp_ready, s_busy;

  int checks   = 0;
  int failures = 0;
  int rr_m     = 0;

  always #5 clk = ~clk;

  s2c_req_arb #(.NCH(NCH), .DATA_SIZE(DS), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_gnt(ch_gnt), .ch_done(ch_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .br_valid(br_valid), .br_data(br_data), .br_ready(br_ready),
    .br_rsp_valid(br_rsp_valid), .br_rsp_data(br_rsp_data), .br_rsp_ready(br_rsp_ready),
    .busy(busy)
  );

  s2c_req_arb #(.NCH(2), .DATA_SIZE(1), .WIDTH(W), .TIMEOUT_CYC(TO)) u_small (
    .clk(clk), .rst_n(rst_n), .ch_req(s_ch_req), .ch_gnt(s_ch_gnt), .ch_done(s_ch_done),
    .tx_valid(s_tx_valid), .tx_data(s_tx_data), .tx_ready(s_tx_ready),
    .rx_valid(s_rx_valid), .rx_data(s_rx_data), .rx_ready(s_rx_ready),
    .br_valid(s_br_valid), .br_data(s_br_data), .br_ready(s_br_ready),
    .br_rsp_valid(s_br_rsp_valid), .br_rsp_data(s_br_rsp_data), .br_rsp_ready(s_br_rsp_ready),
    .busy(s_busy)
  );

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NCH-1:0] req, input int ptr);
    for (int i = 0; i < NCH; i++)
      if (req[(ptr + i) % NCH]) return (ptr + i) % NCH;
    return 0;
  endfunction

  task automatic idle_inputs();
    ch_req = '0; tx_valid = 0; tx_data = '0; rx_ready = 0;
    br_ready = 0; br_rsp_valid = 0; br_rsp_data = '0;
    s_ch_req = '0; s_tx_valid = 0; s_tx_data = '0; s_rx_ready = 0;
    s_br_ready = 0; s_br_rsp_valid = 0; s_br_rsp_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    rr_m  = 0;
  endtask

  // One full transaction for whichever channel the model says wins; optionally the
  // granted channel drops its request mid-transaction, which must not disturb it.
  task automatic run_txn(input int bp, input bit fixed, input bit drop, input string tag);
    logic [W-1:0]   req_pkt [DS+1];
    logic [W-1:0]   rsp_pkt [DS+1];
    logic [W-1:0]   got_br[$], got_rx[$];
    logic [NCH-1:0] gval, dval, exp_oh;
    int exp, txi, rsi, cyc, errs;
    bit fin;
    exp    = model_pick(ch_req, rr_m);
    rr_m   = (exp + 1) % NCH;
    exp_oh = NCH'(1) << exp;
    for (int i = 0; i <= DS; i++) begin
      req_pkt[i] = fixed ? ((i == 0) ? W'(32'h12) : W'(i - 1))   : W'($urandom);
      rsp_pkt[i] = fixed ? ((i == 0) ? W'(32'h5)  : W'(i - 1 + 100)) : W'($urandom);
    end
    txi = 0; rsi = 0; cyc = 0; fin = 0; gval = '0; dval = '0;
    while (!fin && cyc < 3000) begin
      @(negedge clk); cyc++;
      br_ready     = ($urandom_range(99) >= bp);
      rx_ready     = ($urandom_range(99) >= bp);
      tx_valid     = ch_gnt[exp] && (txi <= DS);
      tx_data      = (txi <= DS) ? req_pkt[txi] : '0;
      br_rsp_valid = (got_br.size() == DS + 2) && (rsi <= DS);
      br_rsp_data  = (rsi <= DS) ? rsp_pkt[rsi] : '0;
      if (drop && gval != '0) ch_req[exp] = 1'b0;
      #1;
      if (gval == '0) gval = ch_gnt;
      if (br_valid && br_ready) got_br.push_back(br_data);
      if (tx_valid && tx_ready) txi++;
      if (rx_valid && rx_ready) got_rx.push_back(rx_data);
      if (br_rsp_valid && br_rsp_ready) rsi++;
      if (ch_done != '0) begin dval = ch_done; fin = 1; end
    end
    checks++;
    if (!fin) begin failures++; $display("FAIL %s no ch_done within budget (cycles=%0d)", tag, cyc); end
    checks++;
    if (gval !== exp_oh) begin failures++; $display("FAIL %s grant got=%b exp=%b", tag, gval, exp_oh); end
    checks++;
    if (got_br.size() != DS + 2) begin failures++; $display("FAIL %s bridge word count got=%0d exp=%0d", tag, got_br.size(), DS + 2); end
    errs = 0;
    for (int i = 0; i < got_br.size() && i < DS + 2; i++)
      if (got_br[i] !== ((i == 0) ? W'(exp) : req_pkt[i-1])) errs++;
    checks++;
    if (errs != 0 || got_br.size() == 0) begin failures++; $display("FAIL %s bridge words wrong=%0d first got=%h exp=%h", tag, errs, (got_br.size() > 0) ? got_br[0] : 'x, W'(exp)); end
    checks++;
    if (got_rx.size() != DS + 1) begin failures++; $display("FAIL %s response word count got=%0d exp=%0d", tag, got_rx.size(), DS + 1); end
    errs = 0;
    for (int i = 0; i < got_rx.size() && i <= DS; i++)
      if (got_rx[i] !== rsp_pkt[i]) errs++;
    checks++;
    if (errs != 0 || got_rx.size() == 0) begin failures++; $display("FAIL %s response words wrong=%0d", tag, errs); end
    checks++;
    if (dval !== exp_oh) begin failures++; $display("FAIL %s ch_done got=%b exp=%b", tag, dval, exp_oh); end
    @(negedge clk);
    tx_valid = 0; br_rsp_valid = 0;
    #1;
    checks++;
    if (ch_done !== '0 || busy !== 1'b0) begin failures++; $display("FAIL %s after done ch_done=%b busy=%b exp 0/0", tag, ch_done, busy); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    tx_valid = 1; br_ready = 1; br_rsp_valid = 1; rx_ready = 1; ch_req = '1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ch_gnt, ch_done, busy} !== '0) begin failures++; $display("FAIL reset gnt=%b done=%b busy=%b exp 0", ch_gnt, ch_done, busy); end
    checks++;
    if ({tx_ready, rx_valid, br_valid, br_rsp_ready} !== 4'b0) begin failures++; $display("FAIL reset handshakes=%b exp 0000", {tx_ready, rx_valid, br_valid, br_rsp_ready}); end
    checks++;
    if (br_data !== '0 || rx_data !== '0) begin failures++; $display("FAIL reset data br=%h rx=%h exp 0", br_data, rx_data); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1; rr_m = 0;
  endtask

  task automatic test_single();
    ch_req = 4'b0100;
    run_txn(0, 1'b1, 1'b0, "single");
    ch_req = '0;
  endtask

  task automatic test_rr();
    ch_req = 4'b1111;
    for (int i = 0; i < 5; i++) run_txn(0, 1'b0, 1'b0, "rr_all");
    ch_req = '0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) begin
      ch_req = NCH'($urandom_range(1, (1 << NCH) - 1));
      run_txn(30, 1'b0, i[0], "backpressure");
    end
    ch_req = '0;
  endtask

  task automatic test_reset_mid();
    int nb, cyc;
    nb = 0; cyc = 0;
    ch_req = 4'b1000; br_ready = 1;
    while (nb < 7 && cyc < 200) begin
      @(negedge clk); cyc++;
      tx_valid = ch_gnt[3];
      tx_data  = W'($urandom);
      #1;
      if (tx_valid && tx_ready) nb++;
    end
    checks++;
    if (nb != 7) begin failures++; $display("FAIL reset_mid body words got=%0d exp=7", nb); end
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({ch_gnt, ch_done, tx_ready, rx_valid, br_valid, br_rsp_ready, busy} !== '0) begin
      failures++;
      $display("FAIL reset_mid outputs gnt=%b done=%b txr=%b rxv=%b brv=%b brr=%b busy=%b exp 0",
               ch_gnt, ch_done, tx_ready, rx_valid, br_valid, br_rsp_ready, busy);
    end
    checks++;
    if (br_data !== '0) begin failures++; $display("FAIL reset_mid br_data got=%h exp 0", br_data); end
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1; rr_m = 0;
    ch_req = 4'b0010;
    run_txn(0, 1'b0, 1'b0, "after_reset");
    ch_req = '0;
  endtask

  task automatic test_small();
    int cyc, k, bo, bi, so, ri;
    logic [W-1:0] id0;
    logic [1:0]   dn   [2];
    int           nout [2];
    int           nin  [2];
    logic [W-1:0] ids  [2];
    s_ch_req = 2'b11; s_br_ready = 1; s_rx_ready = 1;
    k = 0; cyc = 0; bo = 0; bi = 0; so = 0; ri = 0; id0 = '0;
    while (k < 2 && cyc < 200) begin
      @(negedge clk); cyc++;
      s_tx_valid     = (s_ch_gnt != '0) && (so < 2);
      s_tx_data      = W'(so + 7);
      s_br_rsp_valid = (bo == 3) && (ri < 2);
      s_br_rsp_data  = W'(ri + 40);
      #1;
      if (s_br_valid && s_br_ready) begin if (bo == 0) id0 = s_br_data; bo++; end
      if (s_tx_valid && s_tx_ready) so++;
      if (s_rx_valid && s_rx_ready) bi++;
      if (s_br_rsp_valid && s_br_rsp_ready) ri++;
      if (s_ch_done != '0) begin
        dn[k] = s_ch_done; nout[k] = bo; nin[k] = bi; ids[k] = id0;
        s_ch_req = s_ch_req & ~s_ch_done;
        k++; bo = 0; bi = 0; so = 0; ri = 0;
      end
    end
    s_tx_valid = 0; s_br_rsp_valid = 0; s_ch_req = '0;
    checks++;
    if (k != 2) begin failures++; $display("FAIL small transactions completed got=%0d exp=2", k); end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (dn[j] !== (2'b01 << j) || ids[j] !== W'(j)) begin
        failures++; $display("FAIL small txn%0d done=%b id=%h exp done=%b id=%0d", j, dn[j], ids[j], 2'b01 << j, j);
      end
      checks++;
      if (nout[j] != 3 || nin[j] != 2) begin
        failures++; $display("FAIL small txn%0d words out=%0d in=%0d exp 3/2", j, nout[j], nin[j]);
      end
    end
  endtask

  task automatic test_silent();
    int cyc, nb, t_last, t_first, nacc;
    logic [W-1:0] rx_q[$];
    bit seen_done;
    do_reset();
    ch_req = 4'b0001; br_ready = 1; rx_ready = 1; br_rsp_valid = 0;
    cyc = 0; nb = 0; t_last = -1; t_first = -1; seen_done = 0;
    while (cyc < 1100 && !seen_done) begin
      @(negedge clk); cyc++;
      tx_valid = ch_gnt[0] && (nb <= DS);
      tx_data  = W'(nb);
      #1;
      if (tx_valid && tx_ready) begin nb++; if (nb == DS + 1) t_last = cyc; end
      if (rx_valid && rx_ready) begin if (t_first < 0) t_first = cyc; rx_q.push_back(rx_data); end
      if (ch_done != '0) seen_done = 1;
    end
    ch_req = '0; tx_valid = 0;
    checks++;
    if (t_last < 0) begin failures++; $display("FAIL silent request phase incomplete words=%0d exp=%0d", nb, DS + 1); end
`ifdef S2C_REQ_TIMEOUT_EN
    checks++;
    if (!seen_done || t_first - t_last < TO || t_first - t_last > TO + 2) begin
      failures++; $display("FAIL timeout done=%0d first rsp after %0d cycles exp %0d..%0d", seen_done, t_first - t_last, TO, TO + 2);
    end
    nacc = 0;
    for (int i = 0; i < rx_q.size(); i++)
      if (rx_q[i] !== ((i == 0) ? {W{1'b1}} : '0)) nacc++;
    checks++;
    if (rx_q.size() != DS + 1 || nacc != 0) begin
      failures++; $display("FAIL timeout synthetic words got=%0d bad=%0d exp %0d words", rx_q.size(), nacc, DS + 1);
    end
    nacc = 0; cyc = 0;
    @(negedge clk);
    br_rsp_valid = 1;
    #1;
    checks++;
    if (br_rsp_ready !== 1'b1) begin failures++; $display("FAIL timeout drain br_rsp_ready got=%b exp=1", br_rsp_ready); end
    while (br_rsp_ready && cyc < 100) begin
      nacc++;
      @(negedge clk); cyc++;
      #1;
    end
    br_rsp_valid = 0;
    checks++;
    if (nacc != DS + 1) begin failures++; $display("FAIL timeout drained words got=%0d exp=%0d", nacc, DS + 1); end
`else
    nacc = rx_q.size();
    checks++;
    if (busy !== 1'b1 || seen_done || nacc != 0) begin
      failures++; $display("FAIL silent busy=%b done_seen=%0d rsp_words=%0d exp busy=1 no done no words", busy, seen_done, nacc);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_small();
    do_reset();
    test_rr();
    test_backpressure();
    test_reset_mid();
    test_silent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
